led_channel_driver: RTL and testbench

Parametrised multi-channel LED driver that replaces fixed per-LED logic with run-time configurable channels. Each channel is independently set to off, on, blink or PWM-dimmed through a single-cycle write port. The block sits between the switch/config logic and the board LED pins. It shares one blink timebase and one PWM timebase across all channels so that blinking LEDs stay phase-aligned.

---
 rtl/led_pkg.sv | 16 +
 rtl/tick_divider.sv | 27 ++
 rtl/led_channel_driver.sv | 97 +++++++++
 tb/tb_led_channel_driver.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared LED driver types and default dividers for the 24 MHz HSOSC.
// No logic: latency and backpressure do not apply.
package led_pkg;

    typedef enum logic [1:0] {
        LED_OFF   = 2'd0,
        LED_ON    = 2'd1,
        LED_BLINK = 2'd2,
        LED_PWM   = 2'd3
    } led_mode_t;

    localparam int HSOSC_HZ      = 24_000_000;
    localparam int BLINK_DIV_DEF = 5_000_000;   // 2.4 Hz blink at HSOSC_HZ
    localparam int PWM_DIV_DEF   = 94;

endpackage

// File: rtl/tick_divider.sv
// Free-running 0..DIV-1 counter with a one-cycle tick while at DIV-1 (wraps on that edge).
// Latency: tick is combinational from the counter register; no backpressure.
module tick_divider #(
    parameter int DIV = 94
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt;

    assign tick = (cnt == CW'(DIV - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/led_channel_driver.sv
// Run-time configurable LED channels (off/on/blink/PWM) on shared blink and PWM timebases.
// Latency: write strobe to pin is 2 cycles; write port is always accepted, no backpressure.
module led_channel_driver
    import led_pkg::*;
#(
    parameter int N_CH      = 3,
    parameter int DUTY_W    = 4,
    parameter int BLINK_DIV = BLINK_DIV_DEF,
    parameter int PWM_DIV   = PWM_DIV_DEF,
    localparam int CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [1:0]        cfg_mode,
    input  logic [DUTY_W-1:0] cfg_duty,
    output logic [N_CH-1:0]   led,
    output logic              blink_phase
);

    led_mode_t         mode_q [N_CH];
    logic [DUTY_W-1:0] duty_q [N_CH];
    logic [DUTY_W-1:0] pwm_cnt;
    logic              blink_q;
    logic              blink_tick;
    logic              pwm_tick;
    logic [N_CH-1:0]   led_nxt;

    tick_divider #(.DIV(BLINK_DIV)) u_blink_div (
        .clk   (clk),
        .reset (reset),
        .tick  (blink_tick)
    );

    tick_divider #(.DIV(PWM_DIV)) u_pwm_div (
        .clk   (clk),
        .reset (reset),
        .tick  (pwm_tick)
    );

    // One timebase for all channels keeps every blinking LED phase-aligned.
    always_ff @(posedge clk) begin
        if (reset) begin
            blink_q <= 1'b0;
            pwm_cnt <= '0;
        end else begin
            if (blink_tick) begin
                blink_q <= ~blink_q;
            end
            if (pwm_tick) begin
                pwm_cnt <= pwm_cnt + DUTY_W'(1);
            end
        end
    end

    // Per-channel decode means an out-of-range cfg_ch simply matches nothing.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N_CH; i++) begin
                mode_q[i] <= LED_OFF;
                duty_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (cfg_we && (cfg_ch == CH_W'(i))) begin
                    mode_q[i] <= led_mode_t'(cfg_mode);
                    duty_q[i] <= cfg_duty;
                end
            end
        end
    end

    always_comb begin
        led_nxt = '0;
        for (int i = 0; i < N_CH; i++) begin
            case (mode_q[i])
                LED_OFF:   led_nxt[i] = 1'b0;
                LED_ON:    led_nxt[i] = 1'b1;
                LED_BLINK: led_nxt[i] = blink_q;
                LED_PWM:   led_nxt[i] = (pwm_cnt < duty_q[i]);
                default:   led_nxt[i] = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            led <= '0;
        end else begin
            led <= led_nxt;
        end
    end

    assign blink_phase = blink_q;

endmodule

// File: tb/tb_led_channel_driver.sv
// Scoreboard bench for led_channel_driver with BLINK_DIV=4, PWM_DIV=1, DUTY_W=2, N_CH=3.
// Stimulus queues expected (cycle, led, blink_phase); a negedge monitor pops and compares.
module tb_led_channel_driver;
    import led_pkg::*;

    localparam int BDIV = 4;
    localparam int PERIOD = 4;   // PWM period in cycles with PWM_DIV=1, DUTY_W=2

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cfg_we = 1'b0;
    logic [1:0] cfg_ch = 2'd0;
    logic [1:0] cfg_mode = 2'd0;
    logic [1:0] cfg_duty = 2'd0;
    logic [2:0] led;
    logic       blink_phase;

    int cyc = 0;
    int rst_cyc = 0;
    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        int         cyc;
        logic [2:0] led;
        logic       bp;
        string      nm;
    } exp_t;

    exp_t sb[$];

    led_channel_driver #(
        .N_CH      (3),
        .DUTY_W    (2),
        .BLINK_DIV (BDIV),
        .PWM_DIV   (1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cfg_we      (cfg_we),
        .cfg_ch      (cfg_ch),
        .cfg_mode    (cfg_mode),
        .cfg_duty    (cfg_duty),
        .led         (led),
        .blink_phase (blink_phase)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Blink level after edge c: toggles every BDIV edges counted from the last reset edge.
    function automatic logic exp_bp(input int c);
        return (((c - rst_cyc) / BDIV) % 2) == 1;
    endfunction

    // PWM channel level seen at cycle c: pwm_cnt after edge c-1 compared with duty.
    function automatic logic pwm_led(input int c, input int duty);
        return ((c - 1 - rst_cyc) % PERIOD) < duty;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_at(input int d, input logic [2:0] l, input string nm);
        exp_t e;
        e.cyc = cyc + d;
        e.led = l;
        e.bp  = exp_bp(cyc + d);
        e.nm  = nm;
        sb.push_back(e);
    endtask

    task automatic wr(input int ch, input logic [1:0] m, input logic [1:0] d);
        cfg_we   = 1'b1;
        cfg_ch   = 2'(ch);
        cfg_mode = m;
        cfg_duty = d;
        tick(1);
        cfg_we   = 1'b0;
    endtask

    always @(negedge clk) begin : monitor
        int i;
        i = 0;
        while (i < sb.size()) begin
            if (sb[i].cyc == cyc) begin
                n_vec++;
                if (led !== sb[i].led || blink_phase !== sb[i].bp) begin
                    n_bad++;
                    $display("FAIL %s cyc=%0d got led=%b bp=%b want led=%b bp=%b",
                             sb[i].nm, cyc, led, blink_phase, sb[i].led, sb[i].bp);
                end
                sb.delete(i);
            end else if (sb[i].cyc < cyc) begin
                n_vec++;
                n_bad++;
                $display("FAIL stale_%s cyc=%0d want cyc=%0d", sb[i].nm, cyc, sb[i].cyc);
                sb.delete(i);
            end else begin
                i++;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog cyc=%0d pending=%0d", cyc, sb.size());
        $fatal(1);
    end

    initial begin
        logic b;
        // Reset held for 3 edges, then idle: led stays 0, blink_phase toggles every 4 edges.
        tick(3);
        reset = 1'b0;
        rst_cyc = cyc;
        for (int j = 0; j <= 12; j++) expect_at(j, 3'b000, "idle");
        tick(12);

        // ch1 ON then OFF: 2-cycle strobe-to-pin latency each way.
        wr(1, LED_ON, 2'd0);
        expect_at(0, 3'b000, "on_lat");
        expect_at(1, 3'b010, "on");
        expect_at(2, 3'b010, "on_hold");
        tick(2);
        wr(1, LED_OFF, 2'd0);
        expect_at(0, 3'b010, "off_lat");
        expect_at(1, 3'b000, "off");

        // ch0 and ch2 to BLINK at different times: both follow the delayed shared phase.
        wr(0, LED_BLINK, 2'd0);
        for (int j = 1; j <= 4; j++) begin
            b = exp_bp(cyc + j - 1);
            expect_at(j, {2'b00, b}, "blink_ch0");
        end
        tick(3);
        wr(2, LED_BLINK, 2'd0);
        for (int j = 1; j <= 12; j++) begin
            b = exp_bp(cyc + j - 1);
            expect_at(j, {b, 1'b0, b}, "blink_both");
        end
        tick(12);

        // Consecutive writes to different channels, then PWM duty 0 stays dark.
        wr(2, LED_OFF, 2'd0);
        wr(0, LED_PWM, 2'd0);
        b = exp_bp(cyc - 1);
        expect_at(0, {2'b00, b}, "b2b_diff");
        for (int j = 1; j <= 16; j++) expect_at(j, 3'b000, "pwm_d0");
        tick(16);

        wr(0, LED_PWM, 2'd2);
        for (int j = 1; j <= 8; j++) expect_at(j, {2'b00, pwm_led(cyc + j, 2)}, "pwm_d2");
        tick(8);

        // Same-channel back-to-back: duty 1 shows for one cycle, then duty 3 wins.
        wr(0, LED_PWM, 2'd1);
        wr(0, LED_PWM, 2'd3);
        expect_at(0, {2'b00, pwm_led(cyc, 1)}, "pwm_d1");
        for (int j = 1; j <= 8; j++) expect_at(j, {2'b00, pwm_led(cyc + j, 3)}, "pwm_d3");
        tick(8);

        // All channels ON, then an out-of-range write must change nothing.
        wr(0, LED_ON, 2'd0);
        wr(1, LED_ON, 2'd0);
        wr(2, LED_ON, 2'd0);
        wr(3, LED_OFF, 2'd0);
        for (int j = 1; j <= 8; j++) expect_at(j, 3'b111, "oor_write");
        tick(8);

        // One-cycle reset pulse mid-operation clears config and restarts the blink count.
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        rst_cyc = cyc;
        for (int j = 0; j <= 12; j++) expect_at(j, 3'b000, "mid_reset");
        tick(14);

        while (sb.size() != 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL unchecked_%s want cyc=%0d", sb[0].nm, sb[0].cyc);
            void'(sb.pop_front());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
